// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data; define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow outputs
module sync_fifo #(
  parameter int datasize = 8,
  parameter int addrsize = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [datasize-1:0] wdata,
  input  logic                w_en,
  input  logic                r_en,
  output logic [datasize-1:0] rdata,
  output logic                wfull,
  output logic                rempty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);
  logic [datasize-1:0] mem [2**addrsize];
  logic [addrsize:0]   wptr, rptr;
  logic                push, pop;
  always_comb begin
    rempty = wptr == rptr;
    wfull  = (wptr[addrsize] != rptr[addrsize]) && (wptr[addrsize-1:0] == rptr[addrsize-1:0]);
    push   = w_en && !wfull;
    pop    = r_en && !rempty;
  end
  always_ff @(posedge clk)
    if (rst && push) mem[wptr[addrsize-1:0]] <= wdata;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      rdata <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rdata <= mem[rptr[addrsize-1:0]];
        rptr  <= rptr + 1'b1;
      end
    end
  end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow || (w_en && wfull);
      underflow <= underflow || (r_en && rempty);
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo, flags checked against a queue model
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wdata = '0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] rdata;
  logic       wfull, rempty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
  logic       m_ovf = 1'b0, m_unf = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  sync_fifo #(.datasize(8), .addrsize(4)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .w_en(w_en), .r_en(r_en),
    .rdata(rdata), .wfull(wfull), .rempty(rempty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic cycle(input logic r_v, input logic w, input logic r, input logic [7:0] d);
    bit full_pre, empty_pre;
    @(negedge clk);
    chk("rempty", int'(rempty), int'(model_q.size() == 0));
    chk("wfull", int'(wfull), int'(model_q.size() == 16));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
`endif
    rst = r_v; w_en = w; r_en = r; wdata = d;
    full_pre  = model_q.size() == 16;
    empty_pre = model_q.size() == 0;
    if (!r_v) begin
      model_q.delete();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      m_ovf = 1'b0; m_unf = 1'b0;
`endif
    end else begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      if (w && full_pre) m_ovf = 1'b1;
      if (r && empty_pre) m_unf = 1'b1;
`endif
      if (r && !empty_pre) exp_q.push_back(model_q.pop_front());
      if (w && !full_pre) model_q.push_back(d);
    end
  endtask
  logic [7:0] hold = '0;
  always @(posedge clk) begin
    logic rst_s, r_s, e_s;
    rst_s = rst; r_s = r_en; e_s = rempty;
    #1;
    if (!rst_s) begin
      chk("reset_rdata", int'(rdata), 0);
      hold = '0;
      exp_q.delete();
    end else if (r_s && !e_s) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else begin
        hold = exp_q.pop_front();
        chk("rdata", int'(rdata), int'(hold));
      end
    end else begin
      if (exp_q.size() != 0) begin
        chk("missed_pop", 1, 0);
        void'(exp_q.pop_front());
      end
      chk("rdata_hold", int'(rdata), int'(hold));
    end
  end
  initial begin
    repeat (2) cycle(0, 0, 0, 0);
    for (int i = 0; i <= 16; i++) cycle(1, 1, 0, 8'(i));
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 1, 1, 8'h77);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 8'(i));
    for (int i = 0; i < 17; i++) cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 8'hA5);
    cycle(1, 1, 1, 8'h5A);
    for (int i = 0; i < 15; i++) cycle(1, 1, 0, 8'(8'h80 + i));
    cycle(1, 1, 1, 8'hFF);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 200; i++)
      cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    repeat (3) cycle(1, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
